// File: rtl/elevator_car_controller_pkg.sv
// Shared types and helpers for the three-floor elevator car controller.
package elevator_car_controller_pkg;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_e;

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] fl);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (int'(fl) == i) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic req_above(input logic [NUM_FLOORS-1:0] rq,
                                     input logic [FLOOR_W-1:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(fl)) r = r | rq[i];
    end
    return r;
  endfunction

  function automatic logic req_below(input logic [NUM_FLOORS-1:0] rq,
                                     input logic [FLOOR_W-1:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(fl)) r = r | rq[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_car_controller_sync_edge_detect.sv
// Two-flop synchronizer with a one-cycle edge pulse; FALLING selects the edge.
module sync_edge_detect #(
  parameter bit FALLING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic pulse_o
);

  logic       s1_q, s2_q, s3_q;
  logic [1:0] warm_q;
  logic       armed_q;
  logic       inactive_lvl;

  assign inactive_lvl = FALLING ? s2_q : ~s2_q;

  // The detector only arms once a real sample shows the inactive level, so an
  // input already asserted when reset releases never produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q   <= din_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      warm_q <= {warm_q[0], 1'b1};
      if (warm_q[1] && inactive_lvl) armed_q <= 1'b1;
    end
  end

  assign pulse_o = armed_q & (FALLING ? (s3_q & ~s2_q) : (~s3_q & s2_q));

endmodule

// File: rtl/elevator_car_controller.sv
// Three-floor elevator car sequencer: request latch, direction/step FSM and door dwell timer.
module elevator_car_controller
  import elevator_car_controller_pkg::*;
#(
  parameter int DOOR_TICKS = 3,
  parameter int TOP_FLOOR  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  button1,
  input  logic                  button2,
  input  logic                  button3,
  input  logic                  move_clk,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] req
);

  localparam logic [FLOOR_W-1:0] TOP_F   = FLOOR_W'(TOP_FLOOR);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DOOR_TICKS - 1);

  state_e                  state_q;
  logic [FLOOR_W-1:0]      floor_q;
  logic                    dir_q;
  logic [NUM_FLOORS-1:0]   req_q;
  logic [CNT_W-1:0]        door_cnt_q;

  logic [NUM_FLOORS-1:0]   press;
  logic                    tick;
  logic [NUM_FLOORS-1:0]   here_mask, step_mask, set_vec, req_live;
  logic [FLOOR_W-1:0]      floor_step_d;
  logic                    at_end, step_end, above, below;

  sync_edge_detect #(.FALLING(1'b1)) u_btn0 (.clk(clk), .rst_n(rst_n), .din_i(button1),  .pulse_o(press[0]));
  sync_edge_detect #(.FALLING(1'b1)) u_btn1 (.clk(clk), .rst_n(rst_n), .din_i(button2),  .pulse_o(press[1]));
  sync_edge_detect #(.FALLING(1'b1)) u_btn2 (.clk(clk), .rst_n(rst_n), .din_i(button3),  .pulse_o(press[2]));
  sync_edge_detect #(.FALLING(1'b0)) u_tick (.clk(clk), .rst_n(rst_n), .din_i(move_clk), .pulse_o(tick));

  // A press for the floor whose door is open only restarts the dwell.
  assign here_mask    = floor_mask(floor_q);
  assign set_vec      = press & ~((state_q == ST_DOOR) ? here_mask : '0);
  assign req_live     = req_q | set_vec;
  assign floor_step_d = (state_q == ST_DOWN) ? (floor_q - FLOOR_W'(1)) : (floor_q + FLOOR_W'(1));
  assign step_mask    = floor_mask(floor_step_d);
  assign at_end       = (state_q == ST_UP) ? (floor_q == TOP_F) : (floor_q == '0);
  assign step_end     = (floor_step_d == TOP_F) || (floor_step_d == '0);
  assign above        = req_above(req_q, floor_q);
  assign below        = req_below(req_q, floor_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      floor_q    <= '0;
      dir_q      <= 1'b1;
      req_q      <= '0;
      door_cnt_q <= '0;
    end else begin
      req_q <= req_live;
      case (state_q)
        ST_IDLE: begin
          if (|(req_q & here_mask)) begin
            state_q    <= ST_DOOR;
            door_cnt_q <= '0;
            req_q      <= req_live & ~here_mask;
          end else if (above && below) begin
            state_q <= dir_q ? ST_UP : ST_DOWN;
          end else if (above) begin
            dir_q   <= 1'b1;
            state_q <= ST_UP;
          end else if (below) begin
            dir_q   <= 1'b0;
            state_q <= ST_DOWN;
          end
        end
        ST_UP, ST_DOWN: begin
          // Step first, then test arrival against requests including this cycle's presses.
          if (at_end) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            floor_q <= floor_step_d;
            if (|(req_live & step_mask)) begin
              state_q    <= ST_DOOR;
              door_cnt_q <= '0;
              req_q      <= req_live & ~step_mask;
            end else if (step_end) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DOOR: begin
          if (|(press & here_mask)) begin
            door_cnt_q <= '0;
          end else if (tick) begin
            if (door_cnt_q == CNT_MAX) begin
              state_q    <= ST_IDLE;
              door_cnt_q <= '0;
            end else begin
              door_cnt_q <= door_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_q;
  assign req       = req_q;
  assign moving    = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign door_open = (state_q == ST_DOOR);

endmodule
